pe_relay: RTL

PE_RELAY -- requirements
Module: pe_relay

---
 rtl/pe_relay.sv | 254 +++++++++++++++++++++++++
 1 files changed

// File: rtl/pe_relay.sv
// pe_relay: two neighbour-data relay FIFOs (PE and PU channels) under a small
// run-control FSM. A config write sets the PE-channel relay limit. A run ends
// on eoc or once that many PE words have been pushed. The status word
// reports {overflow, PE words relayed}.
//
// Handshake (both channels): the pop side is first-word-fall-through.
// out_v is high whenever the FIFO holds a word and out shows the head word.
// A word transfers on a rising edge where out_v=1 and rdy_in=1. The push
// side has no back-pressure. in_v=1 in RUN offers a word. It is accepted
// when the FIFO has room; otherwise it is dropped and the overflow flag is
// set.

module pe_relay_fifo #(
    parameter int W  = 16,
    parameter int LD = 2
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         run,
    input  logic         in_v,
    input  logic [W-1:0] in_data,
    input  logic         rdy,
    output logic [W-1:0] out_data,
    output logic         out_v,
    output logic         push,
    output logic         pop,
    output logic         empty,
    output logic         ovf_hit
);
    localparam int DEPTH = 1 << LD;
    localparam int CW    = LD + 1;

    logic [W-1:0]  mem_q [DEPTH];
    logic [LD-1:0] wr_ptr_q, wr_ptr_d;
    logic [LD-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          full;

    assign full     = (count_q == CW'(DEPTH));
    assign empty    = (count_q == '0);
    assign out_v    = !empty;
    assign out_data = out_v ? mem_q[rd_ptr_q] : '0;
    assign push     = run && in_v && !full;
    assign pop      = out_v && rdy;
    // A full FIFO drops the offered word even if a pop frees a slot this cycle.
    assign ovf_hit  = run && in_v && full;

    // Next pointer/count values; pointers wrap naturally at the power-of-two depth.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        if (push && !pop) begin
            count_d = count_q + 1'b1;
        end else if (pop && !push) begin
            count_d = count_q - 1'b1;
        end
    end

    // Pointer and occupancy registers.
    always_ff @(posedge clk) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage write. Contents need no reset because the count gates visibility.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= in_data;
        end
    end
endmodule

module pe_relay #(
    parameter int peId             = 0,
    parameter int dataLen          = 16,
    parameter int memDataLen       = 16,
    parameter int logNumPeMemLanes = 2,
    parameter int logMemNamespaces = 2,
    parameter int logFifoDepth     = 2
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        start,
    input  logic                        eoc,
    input  logic                        mem_wrt_valid,
    input  logic [logNumPeMemLanes-1:0] peId_mem_in,
    input  logic [logMemNamespaces-1:0] mem_data_type,
    input  logic [memDataLen-1:0]       mem_data_input,
    output logic [memDataLen-1:0]       mem_data_output,
    output logic                        inst_eol,
    input  logic [dataLen-1:0]          pe_neigh_data_in,
    input  logic                        pe_neigh_data_in_v,
    input  logic [dataLen-1:0]          pu_neigh_data_in,
    input  logic                        pu_neigh_data_in_v,
    output logic [dataLen-1:0]          pe_neigh_data_out,
    output logic                        pe_neigh_data_out_v,
    input  logic                        pe_neigh_rdy_in,
    output logic [dataLen-1:0]          pu_neigh_data_out,
    output logic                        pu_neigh_data_out_v,
    input  logic                        pu_neigh_rdy_in,
    // Debug view of the FSM: 0=IDLE 1=RUN 2=DRAIN 3=DONE
    output logic [1:0]                  dbg_state
);
    localparam int RL = memDataLen - 1;
    localparam logic [RL-1:0]               CNT_MAX  = '1;
    localparam logic [logNumPeMemLanes-1:0] PE_SEL   = logNumPeMemLanes'(peId);
    localparam logic [logMemNamespaces-1:0] CFG_TYPE = logMemNamespaces'(1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t          state_q, state_d;
    logic [RL-1:0]   relay_limit_q, relay_limit_d;
    logic [RL-1:0]   push_cnt_q, push_cnt_d;
    logic [RL-1:0]   relay_cnt_q, relay_cnt_d;
    logic            ovf_q, ovf_d;
    logic            inst_eol_q, inst_eol_d;
    logic [memDataLen-1:0] mem_out_q, mem_out_d;

    logic run;
    logic cfg_hit;
    logic pe_push, pe_pop, pe_empty, pe_ovf;
    logic pu_push, pu_pop, pu_empty, pu_ovf;
    logic unused_cfg_msb;
    logic unused_pu_flags;

    assign run             = (state_q == S_RUN);
    assign cfg_hit         = mem_wrt_valid && (mem_data_type == CFG_TYPE) && (peId_mem_in == PE_SEL);
    assign unused_cfg_msb  = mem_data_input[memDataLen-1];
    assign unused_pu_flags = pu_push ^ pu_pop;

    pe_relay_fifo #(.W(dataLen), .LD(logFifoDepth)) u_pe_fifo (
        .clk      (clk),
        .reset    (reset),
        .run      (run),
        .in_v     (pe_neigh_data_in_v),
        .in_data  (pe_neigh_data_in),
        .rdy      (pe_neigh_rdy_in),
        .out_data (pe_neigh_data_out),
        .out_v    (pe_neigh_data_out_v),
        .push     (pe_push),
        .pop      (pe_pop),
        .empty    (pe_empty),
        .ovf_hit  (pe_ovf)
    );

    pe_relay_fifo #(.W(dataLen), .LD(logFifoDepth)) u_pu_fifo (
        .clk      (clk),
        .reset    (reset),
        .run      (run),
        .in_v     (pu_neigh_data_in_v),
        .in_data  (pu_neigh_data_in),
        .rdy      (pu_neigh_rdy_in),
        .out_data (pu_neigh_data_out),
        .out_v    (pu_neigh_data_out_v),
        .push     (pu_push),
        .pop      (pu_pop),
        .empty    (pu_empty),
        .ovf_hit  (pu_ovf)
    );

    // Next state, config capture, counters and the registered status outputs.
    always_comb begin
        state_d       = state_q;
        relay_limit_d = relay_limit_q;
        push_cnt_d    = push_cnt_q;
        relay_cnt_d   = relay_cnt_q;
        ovf_d         = ovf_q || pe_ovf || pu_ovf;

        if (pe_pop && (relay_cnt_q != CNT_MAX)) begin
            relay_cnt_d = relay_cnt_q + 1'b1;
        end
        if (pe_push && (push_cnt_q != CNT_MAX)) begin
            push_cnt_d = push_cnt_q + 1'b1;
        end

        case (state_q)
            S_IDLE: begin
                if (cfg_hit) begin
                    relay_limit_d = mem_data_input[RL-1:0];
                end
                if (start) begin
                    state_d     = (relay_limit_q != '0) ? S_RUN : S_DONE;
                    relay_cnt_d = '0;
                    push_cnt_d  = '0;
                    ovf_d       = 1'b0;
                end
            end
            S_RUN: begin
                // The push that reaches the limit ends the run in the same cycle.
                if (eoc || (push_cnt_d >= relay_limit_q)) begin
                    state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (pe_empty && pu_empty) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                if (!start) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        inst_eol_d = (state_d == S_IDLE) || (state_d == S_DONE);
        mem_out_d  = {ovf_d, relay_cnt_d};
    end

    // Control and status registers.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q       <= S_IDLE;
            relay_limit_q <= '0;
            push_cnt_q    <= '0;
            relay_cnt_q   <= '0;
            ovf_q         <= 1'b0;
            inst_eol_q    <= 1'b1;
            mem_out_q     <= '0;
        end else begin
            state_q       <= state_d;
            relay_limit_q <= relay_limit_d;
            push_cnt_q    <= push_cnt_d;
            relay_cnt_q   <= relay_cnt_d;
            ovf_q         <= ovf_d;
            inst_eol_q    <= inst_eol_d;
            mem_out_q     <= mem_out_d;
        end
    end

    assign inst_eol        = inst_eol_q;
    assign mem_data_output = mem_out_q;
    assign dbg_state       = state_q;
endmodule
